symbol_slot_scheduler: RTL and testbench

Shares the single symbol slot of the DAC transmit path between NUM_REQ symbol sources (payload, pilot, training, test).
- Arbitrates once per symbol period, on the sym_clk_ena strobe from the clock divider.
- Registers the winning symbol and tracks the sample phase within the symbol using sam_clk_ena.
- Sits between the source FIFOs/generators and the pulse-shaping filter; all logic runs on clock_50.

---
 rtl/symbol_slot_scheduler.sv | 155 +++++++++++++++
 tb/tb_symbol_slot_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/symbol_slot_scheduler.sv
// rtl/symbol_slot_scheduler.sv - per-symbol slot arbiter for the DAC transmit path
// Define STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module symbol_slot_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int SYM_W       = 2,
    parameter int SAM_PER_SYM = 4,
    parameter int IDLE_SYM    = 0
) (
    input  logic                           clock_50,
    input  logic                           reset,
    input  logic                           sched_en,
    input  logic                           sam_clk_ena,
    input  logic                           sym_clk_ena,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*SYM_W-1:0]       sym_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [SYM_W-1:0]               sym_out,
    output logic                           sym_valid,
    output logic [$clog2(NUM_REQ)-1:0]     src_id,
    output logic [$clog2(SAM_PER_SYM)-1:0] sam_idx,
    output logic [15:0]                    underrun_cnt,
    output logic                           align_err
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = $clog2(SAM_PER_SYM);
    localparam logic [SYM_W-1:0] IDLE_V  = SYM_W'(IDLE_SYM);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SAM_PER_SYM - 1);

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_ARM = 2'd1;
    localparam logic [1:0] ST_RUN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [SYM_W-1:0] sym_out_q, sym_out_d;
    logic             sym_valid_q, sym_valid_d;
    logic [ID_W-1:0]  src_id_q, src_id_d;
    logic [IDX_W-1:0] sam_idx_q, sam_idx_d;
    logic [15:0]      underrun_q, underrun_d;
    logic             align_err_q, align_err_d;

    logic            arb;
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] lo_win;

    // Lowest requesting index; doubles as the wrap-around candidate for round-robin.
    always_comb begin
        lo_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) lo_win = ID_W'(i);
        end
    end

`ifdef STRICT_PRIO_EN
    always_comb begin
        win = lo_win;
    end
`else
    logic            hi_found;
    logic [ID_W-1:0] hi_win;

    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) > last_q)) begin
                hi_found = 1'b1;
                hi_win   = ID_W'(i);
            end
        end
        win = hi_found ? hi_win : lo_win;
    end
`endif

    assign found = |req;
    // A RUN cycle arbitrates even while sched_en drops so an issued grant completes.
    assign arb   = sym_clk_ena && ((state_q == ST_RUN) || ((state_q == ST_ARM) && sched_en));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        src_id_d    = src_id_q;
        sam_idx_d   = sam_idx_q;
        underrun_d  = underrun_q;
        align_err_d = align_err_q;
        gnt         = '0;

        case (state_q)
            ST_OFF:  state_d = sched_en ? ST_ARM : ST_OFF;
            ST_ARM:  state_d = !sched_en ? ST_OFF : (sym_clk_ena ? ST_RUN : ST_ARM);
            ST_RUN:  state_d = sched_en ? ST_RUN : ST_OFF;
            default: state_d = ST_OFF;
        endcase

        if (arb) begin
            if (found) begin
                gnt         = NUM_REQ'(1) << win;
                sym_out_d   = sym_in[win*SYM_W +: SYM_W];
                sym_valid_d = 1'b1;
                src_id_d    = win;
                last_d      = win;
            end else begin
                sym_out_d   = IDLE_V;
                sym_valid_d = 1'b0;
                if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
            end
        end else if ((state_q == ST_OFF) && sym_clk_ena) begin
            sym_out_d   = IDLE_V;
            sym_valid_d = 1'b0;
        end

        if (state_q == ST_OFF) begin
            sam_idx_d = '0;
        end else if (sam_clk_ena) begin
            sam_idx_d = sym_clk_ena ? '0 : sam_idx_q + IDX_W'(1);
        end

        if ((state_q == ST_RUN) && sym_clk_ena && (!sam_clk_ena || (sam_idx_q != IDX_MAX)))
            align_err_d = 1'b1;

        if (reset) gnt = '0;
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q     <= ST_OFF;
            last_q      <= ID_W'(NUM_REQ - 1);
            sym_out_q   <= IDLE_V;
            sym_valid_q <= 1'b0;
            src_id_q    <= '0;
            sam_idx_q   <= '0;
            underrun_q  <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            src_id_q    <= src_id_d;
            sam_idx_q   <= sam_idx_d;
            underrun_q  <= underrun_d;
            align_err_q <= align_err_d;
        end
    end

    assign sym_out      = sym_out_q;
    assign sym_valid    = sym_valid_q;
    assign src_id       = src_id_q;
    assign sam_idx      = sam_idx_q;
    assign underrun_cnt = underrun_q;
    assign align_err    = align_err_q;
endmodule

// File: tb/tb_symbol_slot_scheduler.sv
// tb/tb_symbol_slot_scheduler.sv - scoreboard bench for symbol_slot_scheduler
module tb_symbol_slot_scheduler;
`ifdef STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, sched_en, sam, sym;
    logic [3:0]  req;
    logic [7:0]  sym_in;
    logic [3:0]  gnt;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic [1:0]  src_id;
    logic [1:0]  sam_idx;
    logic [15:0] underrun_cnt;
    logic        align_err;

    always #5 clk = ~clk;

    symbol_slot_scheduler #(
        .NUM_REQ(4), .SYM_W(2), .SAM_PER_SYM(4), .IDLE_SYM(0)
    ) dut (
        .clock_50(clk), .reset(reset), .sched_en(sched_en),
        .sam_clk_ena(sam), .sym_clk_ena(sym), .req(req), .sym_in(sym_in),
        .gnt(gnt), .sym_out(sym_out), .sym_valid(sym_valid), .src_id(src_id),
        .sam_idx(sam_idx), .underrun_cnt(underrun_cnt), .align_err(align_err)
    );

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  sym;
        logic        valid;
        logic [1:0]  src;
        logic [15:0] under;
        logic        align;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   pend     = 1'b0;
    logic [3:0] cap_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic v,
                                input logic [1:0] src, input logic [15:0] u, input logic a);
        exp_t e;
        e.gnt = g; e.sym = s; e.valid = v; e.src = src; e.under = u; e.align = a;
        return e;
    endfunction

    function automatic logic [3:0] oh(input int k);
        return 4'b0001 << k;
    endfunction

    // Monitor: gnt is captured in the strobe cycle, registered outputs one clock later.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt",          {28'd0, cap_gnt},      {28'd0, e.gnt});
                check("sym_out",      {30'd0, sym_out},      {30'd0, e.sym});
                check("sym_valid",    {31'd0, sym_valid},    {31'd0, e.valid});
                check("src_id",       {30'd0, src_id},       {30'd0, e.src});
                check("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, e.under});
                check("align_err",    {31'd0, align_err},    {31'd0, e.align});
                check("sam_idx",      {30'd0, sam_idx},      32'd0);
            end
        end
        if (mon_en && !reset) begin
            if (sym) begin
                cap_gnt = gnt;
                pend    = 1'b1;
            end else begin
                check("gnt_idle", {28'd0, gnt}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int len, input bit strobe, input exp_t e);
        if (strobe) exp_q.push_back(e);
        for (int c = 0; c < len; c++) begin
            sam = (c % 4 == 0);
            sym = strobe && (c == 0);
            tick();
        end
        sam = 1'b0;
        sym = 1'b0;
    endtask

    initial begin
        exp_t none;
        int   s;
        none = mk(0, 0, 0, 0, 0, 0);
        reset = 1'b1; sched_en = 1'b0; sam = 1'b0; sym = 1'b0; req = '0; sym_in = '0;
        repeat (3) tick();
        check("rst_gnt",       {28'd0, gnt},          32'd0);
        check("rst_sym_out",   {30'd0, sym_out},      32'd0);
        check("rst_sym_valid", {31'd0, sym_valid},    32'd0);
        check("rst_src_id",    {30'd0, src_id},       32'd0);
        check("rst_sam_idx",   {30'd0, sam_idx},      32'd0);
        check("rst_underrun",  {16'd0, underrun_cnt}, 32'd0);
        check("rst_align_err", {31'd0, align_err},    32'd0);

        reset = 1'b0; mon_en = 1'b1; sched_en = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) run(16, 1'b1, mk(0, 0, 0, 0, 16'(k), 0));

        req = 4'b1111; sym_in = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
            s = STRICT ? 0 : k % 4;
            run(16, 1'b1, mk(oh(s), 2'(s), 1, 2'(s), 3, 0));
        end

        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            s = STRICT ? 0 : ((k % 2 == 0) ? 2 : 0);
            run(16, 1'b1, mk(oh(s), 2'(s), 1, 2'(s), 3, 0));
        end

        s = STRICT ? 0 : 2;
        run(8,  1'b1, mk(oh(s), 2'(s), 1, 2'(s), 3, 0));
        run(16, 1'b1, mk(oh(0), 0, 1, 0, 3, 1));
        run(16, 1'b1, mk(oh(s), 2'(s), 1, 2'(s), 3, 1));

        req = 4'b0100;
        run(6, 1'b1, mk(4'b0100, 2, 1, 2, 3, 1));
        sched_en = 1'b0;
        run(10, 1'b0, none);
        run(16, 1'b1, mk(0, 0, 0, 2, 3, 1));
        sched_en = 1'b1;
        run(8, 1'b0, none);
        run(16, 1'b1, mk(4'b0100, 2, 1, 2, 3, 1));

        mon_en = 1'b0; reset = 1'b1; req = '0;
        repeat (2) tick();
        reset = 1'b0; sched_en = 1'b1;
        tick();
        sam = 1'b1; sym = 1'b1;
        repeat (65534) tick();
        sam = 1'b0; sym = 1'b0;
        tick();
        check("fill_underrun",  {16'd0, underrun_cnt}, 32'd65534);
        check("fill_align_err", {31'd0, align_err},    32'd1);
        mon_en = 1'b1;
        run(16, 1'b1, mk(0, 0, 0, 0, 16'hFFFF, 1));
        run(16, 1'b1, mk(0, 0, 0, 0, 16'hFFFF, 1));
        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
